univ_shift_reg: RTL

- Parametrised universal shift register; successor to the single-bit serial-in/serial-out register.
- Supports hold, shift right, shift left and parallel load, selected per cycle by a mode input.
- Exposes the full register, a serial output at each end, and a frame counter that pulses frame_done after every WIDTH consecutive shifts.
- Used as the common serialiser/deserialiser stage in front of the UART and SPI blocks.

---
 rtl/univ_shift_reg_if.sv | 28 ++
 rtl/univ_shift_reg.sv | 88 ++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// Bundle for the universal shift register: control and data in, register state and serial taps out.
// The master drives mode, serial and parallel data; the slave (the register) returns its state.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             en;
    logic [1:0]       mode;
    logic             si_r;
    logic             si_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             frame_done;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output en, mode, si_r, si_l, pin,
        input  q, so_r, so_l, frame_done, bit_cnt
    );

    modport slave (
        input  en, mode, si_r, si_l, pin,
        output q, so_r, so_l, frame_done, bit_cnt
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a
// shared shift counter that pulses frame_done after every WIDTH shifts.
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    univ_shift_reg_if.slave  sr
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             done_reg;
    logic             done_next;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    mode_e            mode_sel;

    // Shifted candidates: each bit takes its neighbour, serial inputs fill the vacated end.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shr_vec[gi]     = q_reg[gi + 1];
            assign shl_vec[gi + 1] = q_reg[gi];
        end
    endgenerate
    assign shr_vec[WIDTH-1] = sr.si_r;
    assign shl_vec[0]       = sr.si_l;

    assign mode_sel = mode_e'(sr.mode);

    always_comb begin
        q_next    = q_reg;
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        if (sr.en) begin
            case (mode_sel)
                MODE_SHR, MODE_SHL: begin
                    q_next = (mode_sel == MODE_SHR) ? shr_vec : shl_vec;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next  = '0;
                        done_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                // A load restarts the frame, so a wrap on the same cycle is dropped.
                MODE_LOAD: begin
                    q_next   = sr.pin;
                    cnt_next = '0;
                end
                default: begin
                    q_next   = q_reg;
                    cnt_next = cnt_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg    <= RST_VAL;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

    assign sr.q          = q_reg;
    assign sr.bit_cnt    = cnt_reg;
    assign sr.frame_done = done_reg;
    assign sr.so_r       = q_reg[0];
    assign sr.so_l       = q_reg[WIDTH-1];
endmodule
